// File: rtl/pipelined_divider.sv
// pipelined_divider: fully pipelined restoring divider, one division per cycle with global stall.
// Define DIV_SIGNED_EN for two's-complement signed division; otherwise operands and results are unsigned.
module pipelined_divider #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_STAGE = 1
) (
   input  logic             CLK,
   input  logic             RSTa,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] num_i,
   input  logic [WIDTH-1:0] den_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o,
   output logic             div_by_zero_o,
   output logic             ovf_o
);
   localparam int STAGES = WIDTH / BITS_PER_STAGE;

   if (WIDTH < 2 || WIDTH % BITS_PER_STAGE != 0) begin : g_bad_cfg
      $error("pipelined_divider: WIDTH must be >= 2 and a multiple of BITS_PER_STAGE");
   end

   typedef struct packed {
      logic             v;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] m;
      logic             sn;
      logic             sd;
      logic             dz;
      logic             ov;
   } stage_t;

   stage_t           st_q [0:STAGES];
   stage_t           st_d [0:STAGES];
   stage_t           tail;
   logic             stall;
   logic             out_valid_q;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dz_q, ovf_q;

   // A never exceeds the dividend prefix seen so far, so shifting out A's MSB loses nothing
   function automatic stage_t step(input stage_t s);
      step = s;
      for (int b = 0; b < BITS_PER_STAGE; b++) begin
         {step.a, step.q} = {step.a[WIDTH-2:0], step.q, 1'b0};
         if (step.a >= step.m) begin
            step.a    = step.a - step.m;
            step.q[0] = 1'b1;
         end
      end
   endfunction

   assign stall      = out_valid_q & ~out_ready_i;
   assign in_ready_o = ~stall;
   assign tail       = st_q[STAGES];

   always_comb begin
      st_d[0]    = '0;
      st_d[0].v  = in_valid_i;
      st_d[0].dz = den_i == '0;
`ifdef DIV_SIGNED_EN
      st_d[0].sn = num_i[WIDTH-1];
      st_d[0].sd = den_i[WIDTH-1];
      st_d[0].q  = num_i[WIDTH-1] ? -num_i : num_i;
      st_d[0].m  = den_i[WIDTH-1] ? -den_i : den_i;
      st_d[0].ov = num_i == {1'b1, {(WIDTH-1){1'b0}}} && &den_i;
`else
      st_d[0].q  = num_i;
      st_d[0].m  = den_i;
`endif
      for (int i = 1; i <= STAGES; i++) st_d[i] = step(st_q[i-1]);
   end

   // Divide by zero leaves Q all-ones and A = |num|; only the quotient sign fix must be bypassed
   always_comb begin
`ifdef DIV_SIGNED_EN
      quot_d = tail.dz ? '1 : (tail.sn ^ tail.sd) ? -tail.q : tail.q;
      rem_d  = tail.sn ? -tail.a : tail.a;
`else
      quot_d = tail.dz ? '1 : tail.q;
      rem_d  = tail.a;
`endif
   end

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         for (int i = 0; i <= STAGES; i++) st_q[i] <= '0;
         out_valid_q <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (!stall) begin
         for (int i = 0; i <= STAGES; i++) st_q[i] <= st_d[i];
         out_valid_q <= tail.v;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         dz_q        <= tail.dz;
         ovf_q       <= tail.ov;
      end
   end

   assign out_valid_o   = out_valid_q;
   assign quot_o        = quot_q;
   assign rem_o         = rem_q;
   assign div_by_zero_o = dz_q;
   assign ovf_o         = ovf_q;
endmodule

// File: tb/tb_pipelined_divider.sv
// tb_pipelined_divider: directed checks of reset, latency, sign handling, corners, streaming, stall and reset flush.
// Expected values follow DIV_SIGNED_EN when it is defined for the build, unsigned results otherwise.
module tb_pipelined_divider;
`ifdef DIV_SIGNED_EN
   localparam bit SG = 1'b1;
`else
   localparam bit SG = 1'b0;
`endif
   localparam logic [7:0] BN [12] = '{8'd100, 8'd101, 8'd102, 8'd103, 8'd104, 8'd105, 8'd106, 8'd107, 8'd108, 8'd109, 8'd110, 8'd111};
   localparam logic [7:0] BD [12] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
   localparam logic [7:0] BQ [12] = '{8'd100, 8'd50, 8'd34, 8'd25, 8'd20, 8'd17, 8'd15, 8'd13, 8'd12, 8'd10, 8'd10, 8'd9};
   localparam logic [7:0] BR [12] = '{8'd0, 8'd1, 8'd0, 8'd3, 8'd4, 8'd3, 8'd1, 8'd3, 8'd0, 8'd9, 8'd0, 8'd3};
   localparam logic [7:0] SN [3]  = '{8'h9C, 8'h64, 8'h9C};
   localparam logic [7:0] SD [3]  = '{8'h07, 8'hF9, 8'hF9};
   localparam logic [7:0] SQS [3] = '{8'hF2, 8'hF2, 8'h0E};
   localparam logic [7:0] SRS [3] = '{8'hFE, 8'h02, 8'hFE};
   localparam logic [7:0] SQU [3] = '{8'h16, 8'h00, 8'h00};
   localparam logic [7:0] SRU [3] = '{8'h02, 8'h64, 8'h9C};
   localparam logic [7:0] CN [3]  = '{8'hFB, 8'h80, 8'h00};
   localparam logic [7:0] CD [3]  = '{8'h00, 8'hFF, 8'h05};
   localparam logic [7:0] CQS [3] = '{8'hFF, 8'h80, 8'h00};
   localparam logic [7:0] CRS [3] = '{8'hFB, 8'h00, 8'h00};
   localparam logic [7:0] CQU [3] = '{8'hFF, 8'h00, 8'h00};
   localparam logic [7:0] CRU [3] = '{8'hFB, 8'h80, 8'h00};
   localparam logic       CZ [3]  = '{1'b1, 1'b0, 1'b0};
   localparam logic       CO [3]  = '{1'b0, 1'b1, 1'b0};

   logic       CLK = 1'b0;
   logic       RSTa = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic [7:0] num = 8'd0;
   logic [7:0] den = 8'd0;
   logic       in_ready, out_valid, dz, ovf;
   logic [7:0] quot, rem;
   int         total = 0;
   int         bad = 0;

   pipelined_divider #(.WIDTH(8), .BITS_PER_STAGE(1)) dut (
      .CLK(CLK), .RSTa(RSTa),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .num_i(num), .den_i(den),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .quot_o(quot), .rem_o(rem), .div_by_zero_o(dz), .ovf_o(ovf)
   );

   always #5 CLK = ~CLK;

   task automatic test_reset();
      RSTa = 1'b0;
      #3;
      total++;
      if ({out_valid, in_ready, dz, ovf} !== 4'b0100) begin
         bad++;
         $display("FAIL reset_flags out_valid/in_ready/dz/ovf=%b want 0100", {out_valid, in_ready, dz, ovf});
      end
      total++;
      if ({quot, rem} !== 16'h0000) begin
         bad++;
         $display("FAIL reset_data quot=%h rem=%h want 00 00", quot, rem);
      end
      @(posedge CLK);
      @(negedge CLK);
      RSTa = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_latency();
      out_ready = 1'b1;
      in_valid = 1'b1;
      num = 8'd100;
      den = 8'd7;
      for (int k = 1; k <= 12; k++) begin
         @(posedge CLK);
         #1;
         in_valid = 1'b0;
         total++;
         if (out_valid !== 1'(k == 10)) begin
            bad++;
            $display("FAIL latency edge=%0d out_valid=%b want %b", k, out_valid, k == 10);
         end
         if (k == 10) begin
            total++;
            if ({quot, rem, dz, ovf} !== {8'd14, 8'd2, 2'b00}) begin
               bad++;
               $display("FAIL latency_data quot=%h rem=%h dz=%b ovf=%b want 0e 02 0 0", quot, rem, dz, ovf);
            end
         end
      end
   endtask

   task automatic test_signs();
      logic [7:0] eq, er;
      int n;
      for (int t = 0; t < 3; t++) begin
         eq = SG ? SQS[t] : SQU[t];
         er = SG ? SRS[t] : SRU[t];
         out_ready = 1'b1;
         in_valid = 1'b1;
         num = SN[t];
         den = SD[t];
         @(posedge CLK);
         #1;
         in_valid = 1'b0;
         n = 0;
         while (out_valid !== 1'b1 && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
         end
         total++;
         if ({out_valid, quot, rem, dz, ovf} !== {1'b1, eq, er, 2'b00}) begin
            bad++;
            $display("FAIL sign[%0d] valid=%b quot=%h rem=%h dz=%b ovf=%b want 1 %h %h 0 0", t, out_valid, quot, rem, dz, ovf, eq, er);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_corners();
      logic [7:0] eq, er;
      logic eo;
      int n;
      for (int t = 0; t < 3; t++) begin
         eq = SG ? CQS[t] : CQU[t];
         er = SG ? CRS[t] : CRU[t];
         eo = SG ? CO[t] : 1'b0;
         out_ready = 1'b1;
         in_valid = 1'b1;
         num = CN[t];
         den = CD[t];
         @(posedge CLK);
         #1;
         in_valid = 1'b0;
         n = 0;
         while (out_valid !== 1'b1 && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
         end
         total++;
         if ({out_valid, quot, rem, dz, ovf} !== {1'b1, eq, er, CZ[t], eo}) begin
            bad++;
            $display("FAIL corner[%0d] valid=%b quot=%h rem=%h dz=%b ovf=%b want 1 %h %h %b %b", t, out_valid, quot, rem, dz, ovf, eq, er, CZ[t], eo);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      int sent = 0, got = 0, first = 0;
      for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
         out_ready = 1'b1;
         in_valid = sent < 12;
         num = BN[sent % 12];
         den = BD[sent % 12];
         #1;
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_in_ready cyc=%0d in_ready=%b want 1", cyc, in_ready);
         end
         if (out_valid === 1'b1) begin
            if (got == 0) first = cyc;
            total++;
            if ({quot, rem} !== {BQ[got], BR[got]} || cyc != first + got) begin
               bad++;
               $display("FAIL b2b[%0d] cyc=%0d quot=%h rem=%h want cyc=%0d %h %h", got, cyc, quot, rem, first + got, BQ[got], BR[got]);
            end
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge CLK);
         #1;
      end
      in_valid = 1'b0;
      total++;
      if (got != 12) begin
         bad++;
         $display("FAIL b2b_count got=%0d want 12", got);
      end
   endtask

   task automatic test_stall();
      int sent = 0, got = 0, hold = 0;
      for (int cyc = 0; cyc < 80 && got < 12; cyc++) begin
         out_ready = !(got == 2 && hold < 3);
         in_valid = sent < 12;
         num = BN[sent % 12];
         den = BD[sent % 12];
         #1;
         total++;
         if (in_ready !== out_ready) begin
            bad++;
            $display("FAIL stall_in_ready cyc=%0d in_ready=%b want %b", cyc, in_ready, out_ready);
         end
         if (!out_ready) begin
            hold++;
            total++;
            if ({out_valid, quot, rem} !== {1'b1, BQ[2], BR[2]}) begin
               bad++;
               $display("FAIL stall_frozen hold=%0d valid=%b quot=%h rem=%h want 1 %h %h", hold, out_valid, quot, rem, BQ[2], BR[2]);
            end
         end else if (out_valid === 1'b1) begin
            total++;
            if ({quot, rem} !== {BQ[got], BR[got]}) begin
               bad++;
               $display("FAIL stall_seq[%0d] quot=%h rem=%h want %h %h", got, quot, rem, BQ[got], BR[got]);
            end
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge CLK);
         #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      total++;
      if (got != 12 || hold != 3) begin
         bad++;
         $display("FAIL stall_count got=%0d hold=%0d want 12 3", got, hold);
      end
   endtask

   task automatic test_reset_inflight();
      int seen = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         num = BN[i];
         den = BD[i];
         @(posedge CLK);
         #1;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK);
         #1;
      end
      total++;
      if ({out_valid, quot} !== {1'b1, BQ[0]}) begin
         bad++;
         $display("FAIL rst_pre valid=%b quot=%h want 1 %h", out_valid, quot, BQ[0]);
      end
      RSTa = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready, quot, rem, dz, ovf} !== {2'b01, 16'h0000, 2'b00}) begin
         bad++;
         $display("FAIL rst_now valid=%b in_ready=%b quot=%h rem=%h dz=%b ovf=%b want 0 1 00 00 0 0", out_valid, in_ready, quot, rem, dz, ovf);
      end
      @(posedge CLK);
      @(negedge CLK);
      RSTa = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(posedge CLK);
         #1;
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_stale cyc=%0d out_valid=%b want 0", c, out_valid);
         end
      end
      in_valid = 1'b1;
      num = BN[6];
      den = BD[6];
      for (int k = 1; k <= 12; k++) begin
         @(posedge CLK);
         #1;
         in_valid = 1'b0;
         if (out_valid === 1'b1 && seen == 0) begin
            seen = k;
            total++;
            if ({quot, rem} !== {BQ[6], BR[6]}) begin
               bad++;
               $display("FAIL rst_next_data quot=%h rem=%h want %h %h", quot, rem, BQ[6], BR[6]);
            end
         end
      end
      total++;
      if (seen != 10) begin
         bad++;
         $display("FAIL rst_next_latency edge=%0d want 10", seen);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_signs();
      test_corners();
      test_back_to_back();
      test_stall();
      test_reset_inflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipelined_divider.md
# pipelined_divider

Fully pipelined restoring divider that takes one WIDTH-bit division per cycle and produces quotient and remainder after a fixed latency. It generalises the single-bit division stage into a complete datapath: parametrised width and bits-per-stage, an input sign-strip stage, iteration stages, and an output sign-fix stage. A valid/ready handshake on both sides supports global stall under backpressure. Divide-by-zero and overflow are flagged. It sits between the operand source and any consumer of the quotient and remainder.

## Interface
- WIDTH, default 8: operand and result width in bits, minimum 2.
- BITS_PER_STAGE, default 1: restoring steps per pipeline stage. WIDTH % BITS_PER_STAGE must be 0, otherwise elaboration fails. STAGES = WIDTH/BITS_PER_STAGE.
- CLK  in  1: clock, rising edge.
- RSTa  in  1: reset, asynchronous, active-low.
- in_valid  in  1: operand pair present.
- in_ready  out  1: block can accept an operand pair this cycle.
- num  in  WIDTH: dividend.
- den  in  WIDTH: divisor.
- out_valid  out  1: result present.
- out_ready  in  1: consumer accepts the result.
- quot  out  WIDTH: quotient.
- rem  out  WIDTH: remainder.
- div_by_zero  out  1: den was 0 for this result.
- ovf  out  1: signed overflow occurred (most-negative / -1).

## Operation
- Pipeline: S0 input register, then S1..S<STAGES> iteration stages, then SO output register. Each stage carries a valid bit plus the fields ACCU, Q, M, sign_num, sign_den, dz and ovf.
- S0 (signed mode):
  - Stores |num| and |den| as WIDTH-bit unsigned values. |most-negative| is 2^(WIDTH-1), which fits.
  - Stores sign_num = num[MSB] and sign_den = den[MSB].
  - Clears ACCU.
  - Sets dz = (den==0) and ovf = (num==most-negative && den==all-ones).
- Each iteration stage performs BITS_PER_STAGE restoring steps combinationally. One step:
  - {A,Q} = {A[W-2:0],Q,1'b0}.
  - If A>=M, then A=A-M and Q[0]=1.
- SO (signed mode):
  - quot = (sign_num^sign_den) ? -Q : Q.
  - rem = sign_num ? -ACCU : ACCU. Quotient truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero: quot is forced to all-ones, rem = num (this falls out of the datapath), and div_by_zero=1.
- Overflow (most-negative / -1): quot = most-negative (e.g. 0x80), rem = 0, ovf = 1.
- Handshake and stall:
  - stall = out_valid & ~out_ready. in_ready = ~stall, combinational.
  - An operand pair is accepted when in_valid & in_ready at a rising edge.
  - While stall=1, every stage register, including SO, holds its value. No entry is lost or duplicated.
  - Bubbles (stage valid=0) advance like data. Their fields are don't-care, but the valid bit must be exact.
- Reset (RSTa low, any time): all valid bits, data fields and outputs go to 0 immediately. In-flight operations are discarded. Reset values: in_ready=1 (because stall=0), out_valid=0, quot=0, rem=0, div_by_zero=0, ovf=0.

## Timing
- Latency: a pair accepted in cycle c is presented in cycle c+STAGES+2 when no stall occurs. For WIDTH=8 and BITS_PER_STAGE=1, latency is 10 cycles.
- Each stall cycle adds exactly one cycle to every in-flight operation.
- Throughput is 1 result/cycle with out_ready held at 1.
- Results emerge strictly in acceptance order.
- quot, rem, div_by_zero and ovf are stable while out_valid=1 and out_ready=0.
- The critical path is BITS_PER_STAGE chained WIDTH-bit compare/subtract steps.

## Configuration
- DIV_SIGNED_EN defined:
  - Two's-complement signed division as described above.
- DIV_SIGNED_EN undefined:
  - Operands and results are unsigned.
  - S0 stores num and den unchanged, and SO applies no negation.
  - ovf is tied to 0.
  - Divide by zero still gives quot = all-ones, rem = num, div_by_zero = 1.
  - Latency is unchanged at STAGES+2.

## Test plan
All scenarios use WIDTH=8, BITS_PER_STAGE=1 with DIV_SIGNED_EN defined.
- 100/7, out_ready=1 -> quot=14, rem=2, out_valid asserted exactly 10 cycles after acceptance, for one cycle.
- Sign combinations:
  - -100/7 -> quot=0xF2 (-14), rem=0xFE (-2).
  - 100/-7 -> quot=-14, rem=2.
  - -100/-7 -> quot=14, rem=-2.
- 12 back-to-back pairs, in_valid=1 and out_ready=1 throughout -> 12 correct results in order on 12 consecutive cycles, in_ready never drops.
- Pipeline full, out_ready=0 for 3 cycles -> in_ready=0 and outputs frozen for those 3 cycles. The following results are the correct sequence with none lost or duplicated.
- Corner cases:
  - -5/0 -> quot=0xFF, rem=0xFB, div_by_zero=1.
  - -128/-1 -> quot=0x80, rem=0, ovf=1.
  - 0/5 -> quot=0, rem=0.
- RSTa pulsed low with 5 operations in flight -> out_valid=0 immediately, no stale result ever appears after release, and the next accepted pair returns after 10 cycles.
